// File: rtl/io_port_responder_pkg.sv
// Shared definitions for the I/O port responder: port map, status and
// control register bit positions, and a small saturation helper.
package io_port_responder_pkg;

  typedef enum logic [2:0] {
    PORT_OUT_A   = 3'd0,
    PORT_OUT_B   = 3'd1,
    PORT_SYNC_IN = 3'd2,
    PORT_STATUS  = 3'd3,
    PORT_TX      = 3'd4,
    PORT_RX      = 3'd5,
    PORT_TIMER   = 3'd6,
    PORT_CTRL    = 3'd7
  } port_addr_e;

  localparam int STAT_TX_FULL     = 3;
  localparam int STAT_RX_NONEMPTY = 2;
  localparam int STAT_TIMER_EXP   = 1;
  localparam int STAT_ERR         = 0;

  localparam int CTRL_IE_TIMER  = 3;
  localparam int CTRL_IE_RX     = 2;
  localparam int CTRL_CLR_TIMER = 1;
  localparam int CTRL_CLR_ERR   = 0;

  function automatic logic [3:0] sat4(input logic [7:0] value);
    return (value > 8'd15) ? 4'hF : value[3:0];
  endfunction

endpackage

// File: rtl/io_port_responder_fifo.sv
// Small 4-bit FIFO used for both the TX and RX streams. Pushes when full and
// pops when empty are ignored, so callers may drive raw strobes.
module port_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [3:0]               i_wdata,
  output logic [3:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // NOTE: storage has no reset; the count and pointers alone define validity.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// Eight-port I/O responder for a small command-controlled device: output
// latches, synchronised inputs, TX/RX FIFOs, a down-counter and an interrupt.
module io_port_responder
  import io_port_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] port_id,
  input  logic       port_read,
  input  logic       port_write,
  input  logic [3:0] cpu_wdata,
  output logic [3:0] cpu_rdata,
  input  logic [3:0] ext_in,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic [3:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [3:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    r_out_a, r_out_b, r_sync_1, r_sync_2, r_timer;
  logic          r_timer_expired, r_err, r_ie_timer, r_ie_rx, r_irq;

  logic          w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [CW-1:0] w_tx_count;
  logic          w_rx_read, w_rx_full, w_rx_empty, w_rx_nonempty;
  logic [CW-1:0] w_rx_count;
  logic [3:0]    w_rx_head;
  logic          w_timer_load, w_timer_set, w_ctrl_wr, w_err_set;
  logic [3:0]    w_status;

  assign w_tx_push     = port_write && (port_id == PORT_TX);
  assign w_tx_pop      = tx_valid && tx_ready;
  assign w_rx_read     = port_read && (port_id == PORT_RX);
  assign w_rx_nonempty = (w_rx_count != '0);
  assign w_timer_load  = port_write && (port_id == PORT_TIMER);
  assign w_ctrl_wr     = port_write && (port_id == PORT_CTRL);
  // A reload in the same cycle pre-empts the 1->0 step, so no expiry.
  assign w_timer_set   = (r_timer == 4'd1) && !w_timer_load;
  assign w_err_set     = (w_tx_push && w_tx_full) || (w_rx_read && w_rx_empty);

  assign tx_valid = !w_tx_empty;
  assign rx_ready = !w_rx_full;
  assign out_a    = r_out_a;
  assign out_b    = r_out_b;
  assign irq      = r_irq;

  port_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_wdata (cpu_wdata),
    .o_head  (tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  port_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (rx_valid),
    .i_pop   (w_rx_read),
    .i_wdata (rx_data),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  always_comb begin
    w_status                   = '0;
    w_status[STAT_TX_FULL]     = w_tx_full;
    w_status[STAT_RX_NONEMPTY] = w_rx_nonempty;
    w_status[STAT_TIMER_EXP]   = r_timer_expired;
    w_status[STAT_ERR]         = r_err;
  end

  always_comb begin
    cpu_rdata = '0;
    if (port_read) begin
      case (port_addr_e'(port_id))
        PORT_OUT_A:   cpu_rdata = r_out_a;
        PORT_OUT_B:   cpu_rdata = r_out_b;
        PORT_SYNC_IN: cpu_rdata = r_sync_2;
        PORT_STATUS:  cpu_rdata = w_status;
        PORT_TX:      cpu_rdata = sat4(8'(w_tx_count));
        PORT_RX:      cpu_rdata = w_rx_empty ? 4'h0 : w_rx_head;
        PORT_TIMER:   cpu_rdata = r_timer;
        PORT_CTRL:    cpu_rdata = {r_ie_timer, r_ie_rx, 2'b00};
        default:      cpu_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_a         <= '0;
      r_out_b         <= '0;
      r_sync_1        <= '0;
      r_sync_2        <= '0;
      r_timer         <= '0;
      r_timer_expired <= 1'b0;
      r_err           <= 1'b0;
      r_ie_timer      <= 1'b0;
      r_ie_rx         <= 1'b0;
      r_irq           <= 1'b0;
    end else begin
      r_sync_1 <= ext_in;
      r_sync_2 <= r_sync_1;
      if (port_write && (port_id == PORT_OUT_A)) r_out_a <= cpu_wdata;
      if (port_write && (port_id == PORT_OUT_B)) r_out_b <= cpu_wdata;

      if (w_timer_load)         r_timer <= cpu_wdata;
      else if (r_timer != '0)   r_timer <= r_timer - 4'd1;

      // Set conditions take priority over software clears.
      if (w_timer_set)                                 r_timer_expired <= 1'b1;
      else if (w_ctrl_wr && cpu_wdata[CTRL_CLR_TIMER]) r_timer_expired <= 1'b0;

      if (w_err_set)                                 r_err <= 1'b1;
      else if (w_ctrl_wr && cpu_wdata[CTRL_CLR_ERR]) r_err <= 1'b0;

      if (w_ctrl_wr) begin
        r_ie_timer <= cpu_wdata[CTRL_IE_TIMER];
        r_ie_rx    <= cpu_wdata[CTRL_IE_RX];
      end

      r_irq <= (r_timer_expired && r_ie_timer) || (w_rx_nonempty && r_ie_rx);
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Self-checking bench for io_port_responder: a vector table, directed
// multi-cycle sequences and random traffic against a queue-based model.
module tb_io_port_responder;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] port_id;
  logic       port_read, port_write;
  logic [3:0] cpu_wdata, cpu_rdata, ext_in, out_a, out_b;
  logic [3:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, irq;

  int n_cmp  = 0;
  int n_fail = 0;

  io_port_responder #(.FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .port_id    (port_id),
    .port_read  (port_read),
    .port_write (port_write),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .ext_in     (ext_in),
    .out_a      (out_a),
    .out_b      (out_b),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  logic [3:0] q_tx[$];
  logic [3:0] q_rx[$];
  logic [3:0] m_a, m_b, m_s1, m_s2, m_tmr;
  logic       m_texp, m_err, m_iet, m_ier, m_irq;

  task automatic model_reset();
    q_tx.delete();
    q_rx.delete();
    m_a = 0; m_b = 0; m_s1 = 0; m_s2 = 0; m_tmr = 0;
    m_texp = 0; m_err = 0; m_iet = 0; m_ier = 0; m_irq = 0;
  endtask

  function automatic logic [3:0] model_rdata();
    if (!port_read) return 4'h0;
    case (port_id)
      3'd0: return m_a;
      3'd1: return m_b;
      3'd2: return m_s2;
      3'd3: return {q_tx.size() == DEPTH, q_rx.size() != 0, m_texp, m_err};
      3'd4: return (q_tx.size() > 15) ? 4'hF : 4'(q_tx.size());
      3'd5: return (q_rx.size() != 0) ? q_rx[0] : 4'h0;
      3'd6: return m_tmr;
      default: return {m_iet, m_ier, 2'b00};
    endcase
  endfunction

  // Advances the model across one rising edge using the current inputs.
  task automatic model_update();
    bit         wr        = port_write;
    logic [3:0] wd        = cpu_wdata;
    bit         tx_full   = (q_tx.size() == DEPTH);
    int         rx_n      = q_rx.size();
    bit         err_set   = 0;
    bit         irq_next  = (m_texp && m_iet) || (rx_n > 0 && m_ier);
    bit         texp_set  = (m_tmr == 4'd1) && !(wr && port_id == 3'd6);
    if (q_tx.size() > 0 && tx_ready) void'(q_tx.pop_front());
    if (wr && port_id == 3'd4) begin
      if (tx_full) err_set = 1;
      else q_tx.push_back(wd);
    end
    if (port_read && port_id == 3'd5) begin
      if (rx_n == 0) err_set = 1;
      else void'(q_rx.pop_front());
    end
    if (rx_valid && rx_n < DEPTH) q_rx.push_back(rx_data);
    if (wr && port_id == 3'd6) m_tmr = wd;
    else if (m_tmr != 0) m_tmr = m_tmr - 4'd1;
    if (texp_set) m_texp = 1;
    else if (wr && port_id == 3'd7 && wd[1]) m_texp = 0;
    if (err_set) m_err = 1;
    else if (wr && port_id == 3'd7 && wd[0]) m_err = 0;
    if (wr && port_id == 3'd7) begin m_iet = wd[3]; m_ier = wd[2]; end
    if (wr && port_id == 3'd0) m_a = wd;
    if (wr && port_id == 3'd1) m_b = wd;
    m_s2 = m_s1;
    m_s1 = ext_in;
    m_irq = irq_next;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [2:0] id, input logic [3:0] wd);
    port_read = rd; port_write = wr; port_id = id; cpu_wdata = wd;
  endtask

  // Compares every observable output with the model on the falling edge.
  task automatic sample();
    @(negedge clock);
    check("cpu_rdata", cpu_rdata, model_rdata());
    check("out_a", out_a, m_a);
    check("out_b", out_b, m_b);
    check("tx_valid", {3'b0, tx_valid}, {3'b0, q_tx.size() != 0});
    check("rx_ready", {3'b0, rx_ready}, {3'b0, q_rx.size() < DEPTH});
    check("irq", {3'b0, irq}, {3'b0, m_irq});
    if (q_tx.size() != 0) check("tx_data", tx_data, q_tx[0]);
  endtask

  task automatic advance();
    model_update();
    @(posedge clock);
    #1;
    port_read = 0; port_write = 0; rx_valid = 0;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic read_expect(input string name, input logic [2:0] id, input logic [3:0] exp);
    drive(1, 0, id, 4'h0);
    sample();
    check(name, cpu_rdata, exp);
    advance();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rd;
    bit         wr;
    logic [2:0] id;
    logic [3:0] wd;
    logic [3:0] exp_rd;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{0, 1, 3'd0, 4'hA, 4'h0, 4'hA, 4'h0});
    vecs.push_back('{0, 1, 3'd1, 4'h5, 4'h0, 4'hA, 4'h5});
    vecs.push_back('{1, 0, 3'd0, 4'h0, 4'hA, 4'hA, 4'h5});
    vecs.push_back('{1, 0, 3'd1, 4'h0, 4'h5, 4'hA, 4'h5});
    vecs.push_back('{1, 1, 3'd0, 4'h3, 4'hA, 4'h3, 4'h5});
    vecs.push_back('{1, 0, 3'd0, 4'h0, 4'h3, 4'h3, 4'h5});
    vecs.push_back('{0, 1, 3'd7, 4'hC, 4'h0, 4'h3, 4'h5});
    vecs.push_back('{1, 0, 3'd7, 4'h0, 4'hC, 4'h3, 4'h5});
    vecs.push_back('{1, 0, 3'd3, 4'h0, 4'h0, 4'h3, 4'h5});
    vecs.push_back('{0, 1, 3'd6, 4'h0, 4'h0, 4'h3, 4'h5});
    vecs.push_back('{1, 0, 3'd3, 4'h0, 4'h0, 4'h3, 4'h5});
    vecs.push_back('{1, 0, 3'd6, 4'h0, 4'h0, 4'h3, 4'h5});
    vecs.push_back('{1, 0, 3'd5, 4'h0, 4'h0, 4'h3, 4'h5});
    vecs.push_back('{1, 0, 3'd3, 4'h0, 4'h1, 4'h3, 4'h5});
    vecs.push_back('{0, 1, 3'd7, 4'h1, 4'h0, 4'h3, 4'h5});
    vecs.push_back('{1, 0, 3'd7, 4'h0, 4'h0, 4'h3, 4'h5});
    vecs.push_back('{1, 0, 3'd3, 4'h0, 4'h0, 4'h3, 4'h5});

    // Power-on reset.
    reset = 1;
    drive(0, 0, 3'd0, 4'h0);
    ext_in = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_a", out_a, 4'h0);
    check("rst_out_b", out_b, 4'h0);
    check("rst_tx_valid", {3'b0, tx_valid}, 4'h0);
    check("rst_rx_ready", {3'b0, rx_ready}, 4'h1);
    check("rst_irq", {3'b0, irq}, 4'h0);
    check("rst_cpu_rdata", cpu_rdata, 4'h0);
    reset = 0;

    // Table-driven single-cycle accesses.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].id, vecs[i].wd);
      sample();
      check($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rd);
      advance();
      check($sformatf("vec%0d_out_a", i), out_a, vecs[i].exp_a);
      check($sformatf("vec%0d_out_b", i), out_b, vecs[i].exp_b);
    end

    // TX fill, overflow and drain.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 3'd4, 4'(i));
      cyc();
    end
    read_expect("tx_status_full", 3'd3, 4'h8);
    drive(0, 1, 3'd4, 4'h5);
    cyc();
    read_expect("tx_status_ovf", 3'd3, 4'h9);
    read_expect("tx_count", 3'd4, 4'h4);
    drive(0, 1, 3'd7, 4'h1);
    cyc();
    tx_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      sample();
      check("drain_valid", {3'b0, tx_valid}, 4'h1);
      check("drain_data", tx_data, 4'(i));
      advance();
    end
    sample();
    check("drain_empty", {3'b0, tx_valid}, 4'h0);
    advance();
    tx_ready = 0;

    // RX push, pop and underflow.
    rx_valid = 1; rx_data = 4'h7;
    cyc();
    rx_valid = 1; rx_data = 4'h9;
    cyc();
    read_expect("rx_pop0", 3'd5, 4'h7);
    read_expect("rx_pop1", 3'd5, 4'h9);
    read_expect("rx_pop_empty", 3'd5, 4'h0);
    read_expect("rx_err_set", 3'd3, 4'h1);
    drive(0, 1, 3'd7, 4'h1);
    cyc();
    read_expect("rx_err_clr", 3'd3, 4'h0);

    // Timer expiry and interrupt.
    drive(0, 1, 3'd7, 4'h8);
    cyc();
    drive(0, 1, 3'd6, 4'h3);
    cyc();
    read_expect("tmr_3", 3'd6, 4'h3);
    read_expect("tmr_2", 3'd6, 4'h2);
    read_expect("tmr_pre_exp", 3'd3, 4'h0);
    drive(1, 0, 3'd3, 4'h0);
    sample();
    check("tmr_exp", cpu_rdata, 4'h2);
    check("irq_lag", {3'b0, irq}, 4'h0);
    advance();
    sample();
    check("irq_rise", {3'b0, irq}, 4'h1);
    advance();
    drive(0, 1, 3'd7, 4'hA);
    cyc();
    drive(1, 0, 3'd7, 4'h0);
    sample();
    check("ctrl_keep_ie", cpu_rdata, 4'h8);
    check("irq_hold", {3'b0, irq}, 4'h1);
    advance();
    drive(1, 0, 3'd3, 4'h0);
    sample();
    check("tmr_exp_clr", cpu_rdata, 4'h0);
    check("irq_fall", {3'b0, irq}, 4'h0);
    advance();

    // Expiry coinciding with a clear: set wins.
    drive(0, 1, 3'd6, 4'h1);
    cyc();
    drive(0, 1, 3'd7, 4'h2);
    cyc();
    read_expect("set_wins", 3'd3, 4'h2);
    drive(0, 1, 3'd7, 4'h2);
    cyc();
    read_expect("clr_after", 3'd3, 4'h0);

    // Input synchroniser latency.
    ext_in = 4'h6;
    read_expect("sync_old0", 3'd2, 4'h0);
    read_expect("sync_old1", 3'd2, 4'h0);
    read_expect("sync_new", 3'd2, 4'h6);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int r = int'($urandom_range(0, 9));
      drive(r < 4 || r == 9, r >= 4, 3'($urandom_range(0, 7)), 4'($urandom));
      tx_ready = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 4'($urandom);
      ext_in   = 4'($urandom);
      cyc();
    end

    // Asynchronous reset with both FIFOs half full and the timer running.
    reset = 1;
    drive(0, 0, 3'd0, 4'h0);
    tx_ready = 0; rx_valid = 0; ext_in = 0;
    #2;
    reset = 0;
    model_reset();
    advance();
    drive(0, 1, 3'd4, 4'h3); cyc();
    drive(0, 1, 3'd4, 4'h4); cyc();
    rx_valid = 1; rx_data = 4'hB; cyc();
    rx_valid = 1; rx_data = 4'hC; cyc();
    drive(0, 1, 3'd0, 4'hF); cyc();
    drive(0, 1, 3'd1, 4'h9); cyc();
    drive(0, 1, 3'd7, 4'h4); cyc();
    drive(0, 1, 3'd6, 4'h9); cyc();
    cyc();
    drive(1, 0, 3'd5, 4'h0);
    #2;
    check("pre_rst_rx_head", cpu_rdata, 4'hB);
    check("pre_rst_tx_valid", {3'b0, tx_valid}, 4'h1);
    check("pre_rst_irq", {3'b0, irq}, 4'h1);
    reset = 1;
    #1;
    check("arst_cpu_rdata", cpu_rdata, 4'h0);
    check("arst_out_a", out_a, 4'h0);
    check("arst_out_b", out_b, 4'h0);
    check("arst_tx_valid", {3'b0, tx_valid}, 4'h0);
    check("arst_rx_ready", {3'b0, rx_ready}, 4'h1);
    check("arst_irq", {3'b0, irq}, 4'h0);
    port_read = 0;
    reset = 0;
    model_reset();
    cyc();
    read_expect("arst_status", 3'd3, 4'h0);
    read_expect("arst_tx_count", 3'd4, 4'h0);
    read_expect("arst_timer", 3'd6, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
